snax_alu_out_narrower: RTL and testbench

//  Output stage directly downstream of the SNAX ALU shell. Consumes each wide result beat
//  (NumPE*DataWidth*2 bits) and emits two narrow beats (NumPE*DataWidth bits) to the streamer write port.

---
 rtl/snax_alu_pkg.sv | 13 +
 rtl/snax_alu_out_fifo.sv | 72 +++++++
 rtl/snax_alu_out_narrower.sv | 148 ++++++++++++++
 tb/tb_snax_alu_out_narrower.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_alu_pkg.sv
// Shared types for the SNAX ALU output narrowing stage.
package snax_alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } out_state_e;

  localparam logic LO_HALF = 1'b0;
  localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/snax_alu_out_fifo.sv
// Registered synchronous FIFO (no fall-through) holding wide ALU result beats.
module snax_alu_out_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_en && !pop_en) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_en && !push_en) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy tracking decides validity.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/snax_alu_out_narrower.sv
// Splits wide SNAX ALU results into two narrow streamer beats and tracks job completion.
// Optional stall counter enabled by defining SNAX_ALU_OUT_STALL_CNT_EN.
module snax_alu_out_narrower
  import snax_alu_pkg::*;
#(
  parameter int unsigned NumPE     = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumPE*DataWidth*2-1:0]    acc_data_i,
  input  logic                            acc_valid_i,
  output logic                            acc_ready_o,
  output logic [NumPE*DataWidth-1:0]      stream_data_o,
  output logic                            stream_valid_o,
  input  logic                            stream_ready_i,
  input  logic [CntWidth-1:0]             cfg_len_i,
  input  logic                            cfg_start_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [CntWidth-1:0]             beat_cnt_o,
  output logic [CntWidth-1:0]             stall_cnt_o
);

  localparam int unsigned NarrowW = NumPE * DataWidth;
  localparam int unsigned WideW   = 2 * NarrowW;

  out_state_e          state_q, state_d;
  logic [CntWidth-1:0] len_q, len_d;
  logic [CntWidth-1:0] in_cnt_q, in_cnt_d;
  logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
  logic                half_sel_q, half_sel_d;
  logic                done_q, done_d;

  logic [WideW-1:0]    head;
  logic                fifo_full, fifo_empty;
  logic                in_hs, out_hs, pop, start_job;

  snax_alu_out_fifo #(
    .Width (WideW),
    .Depth (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_hs),
    .data_i  (acc_data_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign beat_cnt_o     = beat_cnt_q;
  assign acc_ready_o    = (state_q == RUN) && !fifo_full && (in_cnt_q < len_q);
  assign stream_valid_o = !fifo_empty;
  // Data forced to zero when nothing is queued so stale payload never leaks out.
  assign stream_data_o  = fifo_empty ? '0 :
                          (half_sel_q == HI_HALF) ? head[WideW-1:NarrowW] : head[NarrowW-1:0];

  assign in_hs     = acc_valid_i && acc_ready_o;
  assign out_hs    = stream_valid_o && stream_ready_i;
  assign pop       = out_hs && (half_sel_q == HI_HALF);
  assign start_job = (state_q == IDLE) && cfg_start_i && (cfg_len_i != '0);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    beat_cnt_d = beat_cnt_q;
    half_sel_d = half_sel_q;
    done_d     = 1'b0;

    if (out_hs) begin
      half_sel_d = ~half_sel_q;
      if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CntWidth'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start_job) begin
          len_d      = cfg_len_i;
          in_cnt_d   = '0;
          beat_cnt_d = '0;
          state_d    = RUN;
        end else if (cfg_start_i) begin
          done_d = 1'b1;
        end
      end
      RUN: begin
        // acc_ready_o guarantees in_cnt_q < len_q, so the increment cannot wrap.
        if (in_hs) in_cnt_d = in_cnt_q + CntWidth'(1);
        if (in_cnt_d >= len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && (half_sel_q == LO_HALF)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_q      <= '0;
      in_cnt_q   <= '0;
      beat_cnt_q <= '0;
      half_sel_q <= LO_HALF;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      in_cnt_q   <= in_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      half_sel_q <= half_sel_d;
      done_q     <= done_d;
    end
  end

`ifdef SNAX_ALU_OUT_STALL_CNT_EN
  logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_job) begin
      stall_cnt_d = '0;
    end else if (busy_o && stream_valid_o && !stream_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snax_alu_out_narrower.sv
// Self-checking bench for snax_alu_out_narrower: directed scenarios plus randomized scoreboard run.
module tb_snax_alu_out_narrower;

  localparam int unsigned NumPE     = 4;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned FifoDepth = 2;
  localparam int unsigned CntWidth  = 32;
  localparam int unsigned NW        = NumPE * DataWidth;
  localparam int unsigned WW        = 2 * NW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [WW-1:0]       acc_data_i;
  logic                acc_valid_i;
  logic                acc_ready_o;
  logic [NW-1:0]       stream_data_o;
  logic                stream_valid_o;
  logic                stream_ready_i;
  logic [CntWidth-1:0] cfg_len_i;
  logic                cfg_start_i;
  logic                busy_o;
  logic                done_o;
  logic [CntWidth-1:0] beat_cnt_o;
  logic [CntWidth-1:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WW-1:0] src_q[$];
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] obs_q[$];
  int            acc_cnt;
  int            done_cnt;
  int            stall_exp;
  bit            busy_seen;

  always #5 clk = ~clk;

  snax_alu_out_narrower #(
    .NumPE     (NumPE),
    .DataWidth (DataWidth),
    .FifoDepth (FifoDepth),
    .CntWidth  (CntWidth)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .acc_data_i     (acc_data_i),
    .acc_valid_i    (acc_valid_i),
    .acc_ready_o    (acc_ready_o),
    .stream_data_o  (stream_data_o),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .cfg_len_i      (cfg_len_i),
    .cfg_start_i    (cfg_start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .beat_cnt_o     (beat_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // One cycle: drive inputs at negedge, record handshakes into the reference queues.
  task automatic tick(input int vprob, input int rprob);
    logic [WW-1:0] w;
    acc_valid_i    = (src_q.size() > 0) && (int'($urandom_range(99)) < vprob);
    acc_data_i     = (src_q.size() > 0) ? src_q[0] : '0;
    stream_ready_i = (int'($urandom_range(99)) < rprob);
    #1;
    if (acc_valid_i && acc_ready_o) begin
      w = src_q.pop_front();
      exp_q.push_back(w[NW-1:0]);
      exp_q.push_back(w[WW-1:NW]);
      acc_cnt++;
    end
    if (stream_valid_o && stream_ready_i) obs_q.push_back(stream_data_o);
    if (busy_o && stream_valid_o && !stream_ready_i) stall_exp++;
    if (done_o) done_cnt++;
    if (busy_o) busy_seen = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input int vprob, input int rprob, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        ok = 1'b1;
        return;
      end
      tick(vprob, rprob);
    end
    ok = done_o;
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    obs_q.delete();
    acc_cnt   = 0;
    stall_exp = 0;
    done_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic start_job(input int len);
    cfg_len_i   = CntWidth'(len);
    cfg_start_i = 1'b1;
    tick(0, 100);
    cfg_start_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {acc_ready_o, stream_valid_o, busy_o, done_o, |stream_data_o, |beat_cnt_o, |stall_cnt_o, 1'b0};
    n_cmp++;
    if (got !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000000", got);
    end
    rst_n = 1'b1;
    tick(0, 100);
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || stream_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: busy %b done %b valid %b want 0 0 0", busy_o, done_o, stream_valid_o);
    end
  endtask

  task automatic test_basic();
    bit            ok;
    logic [NW-1:0] want;
    clear_model();
    for (int n = 0; n < 3; n++)
      src_q.push_back({NW'(8'h2A + n), NW'(8'h1A + n)});
    start_job(3);
    wait_done(60, 100, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_done: got timeout want done pulse");
    end
    n_cmp++;
    if (beat_cnt_o !== CntWidth'(6)) begin
      n_bad++;
      $display("FAIL basic_beat_cnt: got %0d want 6", beat_cnt_o);
    end
    n_cmp++;
    if (obs_q.size() != 6) begin
      n_bad++;
      $display("FAIL basic_count: got %0d want 6", obs_q.size());
    end
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      want = (k % 2 == 0) ? NW'(8'h1A + k / 2) : NW'(8'h2A + k / 2);
      n_cmp++;
      if (obs_q[k] !== want) begin
        n_bad++;
        $display("FAIL basic_data[%0d]: got %h want %h", k, obs_q[k], want);
      end
    end
    tick(0, 100);
    n_cmp++;
    if (done_o !== 1'b0 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL basic_done_pulse: done %b pulses %0d want 0 and 1", done_o, done_cnt);
    end
  endtask

  task automatic test_stall();
    bit            ok;
    bit            have;
    logic [NW-1:0] held;
    int            want_stall;
    clear_model();
    have = 1'b0;
    held = '0;
    for (int n = 0; n < 4; n++) src_q.push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                                                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    start_job(4);
    // First cycle pushes while the FIFO is still empty, then ten valid-but-blocked cycles.
    for (int i = 0; i < 11; i++) begin
      tick(100, 0);
      if (have) begin
        n_cmp++;
        if (stream_data_o !== held) begin
          n_bad++;
          $display("FAIL stall_hold[%0d]: got %h want %h", i, stream_data_o, held);
        end
      end else if (stream_valid_o) begin
        have = 1'b1;
        held = stream_data_o;
      end
    end
    n_cmp++;
    if (acc_cnt != 2 || acc_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_backpressure: accepted %0d ready %b want 2 0", acc_cnt, acc_ready_o);
    end
`ifdef SNAX_ALU_OUT_STALL_CNT_EN
    want_stall = 10;
`else
    want_stall = 0;
`endif
    n_cmp++;
    if (stall_cnt_o !== CntWidth'(want_stall)) begin
      n_bad++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt_o, want_stall);
    end
    wait_done(80, 100, 100, ok);
    n_cmp++;
    if (!ok || beat_cnt_o !== CntWidth'(8)) begin
      n_bad++;
      $display("FAIL stall_finish: done %b beats %0d want 1 8", ok, beat_cnt_o);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 8) begin
      n_bad++;
      $display("FAIL stall_sb_size: got %0d want %0d (8)", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL stall_sb[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    tick(0, 100);
  endtask

  task automatic test_zero_len();
    clear_model();
    start_job(0);
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || acc_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len_pulse: done %b busy %b ready %b want 1 0 0", done_o, busy_o, acc_ready_o);
    end
    tick(0, 100);
    tick(0, 100);
    n_cmp++;
    if (done_o !== 1'b0 || busy_seen || done_cnt != 1) begin
      n_bad++;
      $display("FAIL zero_len_after: done %b busy_seen %b pulses %0d want 0 0 1", done_o, busy_seen, done_cnt);
    end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    clear_model();
    for (int n = 0; n < 5; n++) src_q.push_back(WW'({$urandom, $urandom, $urandom, $urandom}) << (n * 7));
    start_job(4);
    repeat (3) tick(100, 100);
    cfg_len_i   = CntWidth'(5);
    cfg_start_i = 1'b1;
    tick(100, 100);
    cfg_start_i = 1'b0;
    wait_done(80, 100, 100, ok);
    n_cmp++;
    if (!ok || beat_cnt_o !== CntWidth'(8) || acc_cnt != 4 || src_q.size() != 1) begin
      n_bad++;
      $display("FAIL restart_ignored: done %b beats %0d accepted %0d left %0d want 1 8 4 1",
               ok, beat_cnt_o, acc_cnt, src_q.size());
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL restart_sb_size: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL restart_sb[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    tick(0, 100);
  endtask

  task automatic test_reset_mid_job();
    bit         ok;
    logic [7:0] got;
    clear_model();
    for (int n = 0; n < 4; n++) src_q.push_back({WW{1'b1}} ^ WW'(n));
    start_job(4);
    repeat (4) tick(100, 0);
    n_cmp++;
    if (acc_cnt != 2) begin
      n_bad++;
      $display("FAIL midrst_setup: accepted %0d want 2", acc_cnt);
    end
    rst_n = 1'b0;
    #1;
    got = {acc_ready_o, stream_valid_o, busy_o, done_o, |stream_data_o, |beat_cnt_o, |stall_cnt_o, 1'b0};
    n_cmp++;
    if (got !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %b want 00000000", got);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (5) tick(0, 100);
    n_cmp++;
    if (done_cnt != 0 || stream_valid_o !== 1'b0 || busy_seen) begin
      n_bad++;
      $display("FAIL midrst_quiet: pulses %0d valid %b busy_seen %b want 0 0 0", done_cnt, stream_valid_o, busy_seen);
    end
    src_q.push_back({NW'(32'hCAFE_0002), NW'(32'hCAFE_0001)});
    start_job(1);
    wait_done(40, 100, 100, ok);
    n_cmp++;
    if (!ok || beat_cnt_o !== CntWidth'(2) || obs_q.size() != 2) begin
      n_bad++;
      $display("FAIL midrst_newjob: done %b beats %0d seen %0d want 1 2 2", ok, beat_cnt_o, obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 2; k++) begin
      n_cmp++;
      if (obs_q[k] !== NW'(32'hCAFE_0001 + k)) begin
        n_bad++;
        $display("FAIL midrst_data[%0d]: got %h want %h", k, obs_q[k], NW'(32'hCAFE_0001 + k));
      end
    end
    tick(0, 100);
  endtask

  task automatic test_random();
    bit            ok;
    logic [WW-1:0] w;
    int            want_stall;
    clear_model();
    for (int n = 0; n < 70; n++) begin
      w = '0;
      for (int j = 0; j < int'(WW / 32); j++) w = (w << 32) | WW'($urandom);
      src_q.push_back(w);
    end
    start_job(64);
    wait_done(3000, 60, 60, ok);
    n_cmp++;
    if (!ok || acc_cnt != 64 || src_q.size() != 6) begin
      n_bad++;
      $display("FAIL random_job: done %b accepted %0d left %0d want 1 64 6", ok, acc_cnt, src_q.size());
    end
    n_cmp++;
    if (beat_cnt_o !== CntWidth'(128) || obs_q.size() != 128 || exp_q.size() != 128) begin
      n_bad++;
      $display("FAIL random_count: beats %0d seen %0d model %0d want 128", beat_cnt_o, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL random_sb[%0d]: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
`ifdef SNAX_ALU_OUT_STALL_CNT_EN
    want_stall = stall_exp;
`else
    want_stall = 0;
`endif
    n_cmp++;
    if (stall_cnt_o !== CntWidth'(want_stall)) begin
      n_bad++;
      $display("FAIL random_stall_cnt: got %0d want %0d", stall_cnt_o, want_stall);
    end
    tick(0, 100);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    acc_data_i     = '0;
    acc_valid_i    = 1'b0;
    stream_ready_i = 1'b0;
    cfg_len_i      = '0;
    cfg_start_i    = 1'b0;
    clear_model();
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_restart_ignored();
    test_reset_mid_job();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
